// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the pulse burst generator: FSM state encoding and default widths.
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  localparam int PER_W_DEF = 16;
  localparam int LEN_W_DEF = 16;
  localparam int CO_W_DEF  = 16;

endpackage

// File: rtl/pulse_divider.sv
// Loadable down-counter that reloads itself on reaching zero; usable as a generic prescaler.
module pulse_divider #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  localparam logic [W-1:0] ONE = 1;

  logic [W-1:0] count;
  logic [W-1:0] reload;
  logic [W-1:0] count_next;

  always_comb begin
    count_next = count;
    if (load)
      count_next = load_val;
    else if (en)
      count_next = (count == '0) ? reload : count - ONE;
  end

  // tc flags that the value being written this edge is zero, so a caller can
  // register its strobe in the same cycle the count lands on zero.
  assign tc = (load || en) && (count_next == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      reload <= '0;
    end else begin
      count <= count_next;
      if (load)
        reload <= load_val;
    end
  end

endmodule

// File: rtl/pulse_burst_gen.sv
// Generates a programmable burst of single-cycle count-enable pulses and counts returned carries.
module pulse_burst_gen
  import pulse_gen_pkg::*;
#(
  parameter int PER_W = PER_W_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int CO_W  = CO_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PER_W-1:0] period,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             cout_in,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] pulse_cnt,
  output logic [CO_W-1:0]  cout_cnt
);

  localparam logic [PER_W-1:0] PER_ONE = 1;
  localparam logic [LEN_W-1:0] LEN_ONE = 1;
  localparam logic [CO_W-1:0]  CO_ONE  = 1;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [PER_W-1:0] period_eff;
  logic             accept;
  logic             div_load;
  logic             div_en;
  logic             div_tc;
  logic             last_issued;

  assign period_eff  = (period == '0) ? PER_ONE : period;
  assign accept      = (state == ST_IDLE) && start;
  assign div_load    = accept && (burst_len != '0);
  assign div_en      = (state == ST_RUN);
  assign last_issued = pulse_out && (pulse_cnt == len_q);

  pulse_divider #(.W(PER_W)) u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .load_val (period_eff - PER_ONE),
    .en       (div_en),
    .tc       (div_tc)
  );

  // With period 1 the divider is loaded with zero, so the first pulse
  // already goes out on the acceptance edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pulse_cnt <= '0;
      len_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          pulse_out <= 1'b0;
          done      <= 1'b0;
          if (start) begin
            len_q <= burst_len;
            if (burst_len == '0) begin
              state     <= ST_FIN;
              done      <= 1'b1;
              busy      <= 1'b0;
              pulse_cnt <= '0;
            end else begin
              state     <= ST_RUN;
              busy      <= 1'b1;
              pulse_out <= div_tc;
              pulse_cnt <= div_tc ? LEN_ONE : '0;
            end
          end
        end
        ST_RUN: begin
          if (last_issued) begin
            state     <= ST_FIN;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            pulse_out <= div_tc;
            if (div_tc)
              pulse_cnt <= pulse_cnt + LEN_ONE;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          pulse_out <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

  // Carry counter runs in every state; an accepted start clears it even if a carry arrives that cycle.
  always_ff @(posedge clk) begin
    if (rst)
      cout_cnt <= '0;
    else if (accept)
      cout_cnt <= '0;
    else if (cout_in && (cout_cnt != '1))
      cout_cnt <= cout_cnt + CO_ONE;
  end

endmodule

// File: tb/tb_pulse_burst_gen.sv
// Self-checking bench for pulse_burst_gen: a wide instance plus a CO_W=2 instance sharing stimulus.
module tb_pulse_burst_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] period = 16'd0;
  logic [15:0] burst_len = 16'd0;
  logic        cout_rand = 1'b0;
  logic        cout_in2 = 1'b0;
  logic        use_ctr = 1'b0;

  logic        pulse_a, busy_a, done_a;
  logic [15:0] pcnt_a, ccnt_a;
  logic        pulse_b, busy_b, done_b;
  logic [15:0] pcnt_b;
  logic [1:0]  ccnt_b;

  logic [7:0]  ctr_q;
  logic        ctr_cout;
  logic        cout_a;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Behavioural 8-bit counter standing in for a counter_top driven by pulse_out.
  assign ctr_cout = pulse_a && (ctr_q == 8'hFF);
  assign cout_a   = use_ctr ? ctr_cout : cout_rand;
  always @(posedge clk) begin
    if (rst) ctr_q <= 8'd0;
    else if (pulse_a) ctr_q <= ctr_q + 8'd1;
  end

  pulse_burst_gen dut_a (
    .clk(clk), .rst(rst), .start(start), .period(period), .burst_len(burst_len),
    .cout_in(cout_a), .pulse_out(pulse_a), .busy(busy_a), .done(done_a),
    .pulse_cnt(pcnt_a), .cout_cnt(ccnt_a)
  );

  pulse_burst_gen #(.PER_W(16), .LEN_W(16), .CO_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(start), .period(period), .burst_len(burst_len),
    .cout_in(cout_in2), .pulse_out(pulse_b), .busy(busy_b), .done(done_b),
    .pulse_cnt(pcnt_b), .cout_cnt(ccnt_b)
  );

  // Expected waveform comes from the burst rules: pulses at acceptance+m*P for m=1..L,
  // busy through the last pulse, done one cycle after it.
  task automatic run_burst(input int p, input int l, input bit noise);
    int pe, span, exp_cnt, m_a, m_b;
    bit exp_pulse, exp_busy, exp_done;
    pe   = (p == 0) ? 1 : p;
    span = l * pe;
    @(negedge clk);
    period    = 16'(p);
    burst_len = 16'(l);
    start     = 1'b1;
    cout_rand = 1'($urandom % 2);
    cout_in2  = 1'($urandom % 2);
    @(posedge clk); #1;
    start = 1'b0;
    m_a = 0;
    m_b = 0;
    for (int j = 1; j <= span + 2; j++) begin
      exp_busy  = (l > 0) && (j <= span);
      exp_pulse = exp_busy && (j % pe == 0);
      exp_done  = (j == span + 1);
      exp_cnt   = (l == 0) ? 0 : ((j / pe > l) ? l : j / pe);
      checks++; if (pulse_a !== exp_pulse) begin errors++; $display("[TB] FAIL pulse_a P%0d L%0d c%0d got %b want %b", p, l, j, pulse_a, exp_pulse); end
      checks++; if (busy_a !== exp_busy) begin errors++; $display("[TB] FAIL busy_a P%0d L%0d c%0d got %b want %b", p, l, j, busy_a, exp_busy); end
      checks++; if (done_a !== exp_done) begin errors++; $display("[TB] FAIL done_a P%0d L%0d c%0d got %b want %b", p, l, j, done_a, exp_done); end
      checks++; if (pcnt_a !== 16'(exp_cnt)) begin errors++; $display("[TB] FAIL pulse_cnt_a P%0d L%0d c%0d got %0d want %0d", p, l, j, pcnt_a, exp_cnt); end
      checks++; if (pulse_b !== exp_pulse) begin errors++; $display("[TB] FAIL pulse_b P%0d L%0d c%0d got %b want %b", p, l, j, pulse_b, exp_pulse); end
      checks++; if (busy_b !== exp_busy) begin errors++; $display("[TB] FAIL busy_b P%0d L%0d c%0d got %b want %b", p, l, j, busy_b, exp_busy); end
      checks++; if (done_b !== exp_done) begin errors++; $display("[TB] FAIL done_b P%0d L%0d c%0d got %b want %b", p, l, j, done_b, exp_done); end
      checks++; if (pcnt_b !== 16'(exp_cnt)) begin errors++; $display("[TB] FAIL pulse_cnt_b P%0d L%0d c%0d got %0d want %0d", p, l, j, pcnt_b, exp_cnt); end
      checks++; if (ccnt_b !== 2'(m_b)) begin errors++; $display("[TB] FAIL cout_cnt_b P%0d L%0d c%0d got %0d want %0d", p, l, j, ccnt_b, m_b); end
      if (!use_ctr) begin
        checks++; if (ccnt_a !== 16'(m_a)) begin errors++; $display("[TB] FAIL cout_cnt_a P%0d L%0d c%0d got %0d want %0d", p, l, j, ccnt_a, m_a); end
      end
      cout_rand = 1'($urandom % 2);
      cout_in2  = 1'($urandom % 2);
      if (cout_rand && !use_ctr && m_a < 65535) m_a++;
      if (cout_in2 && m_b < 3) m_b++;
      if (noise && j <= span + 1) begin
        start     = 1'($urandom % 2);
        period    = 16'($urandom_range(0, 9));
        burst_len = 16'($urandom_range(0, 9));
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    cout_rand = 1'b1;
    cout_in2 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({pulse_a, busy_a, done_a} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags_a got %b want 000", {pulse_a, busy_a, done_a}); end
    checks++; if (pcnt_a !== 16'd0) begin errors++; $display("[TB] FAIL reset_pulse_cnt_a got %0d want 0", pcnt_a); end
    checks++; if (ccnt_a !== 16'd0) begin errors++; $display("[TB] FAIL reset_cout_cnt_a got %0d want 0", ccnt_a); end
    checks++; if ({pulse_b, busy_b, done_b} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags_b got %b want 000", {pulse_b, busy_b, done_b}); end
    checks++; if (ccnt_b !== 2'd0) begin errors++; $display("[TB] FAIL reset_cout_cnt_b got %0d want 0", ccnt_b); end
    rst = 1'b0;
    cout_rand = 1'b0;
    cout_in2 = 1'b0;
  endtask

  task automatic test_basic();
    run_burst(6, 3, 1'b0);
  endtask

  task automatic test_period_zero();
    run_burst(0, 4, 1'b0);
    run_burst(1, 1, 1'b0);
  endtask

  task automatic test_zero_len();
    run_burst(5, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_burst(4, 3, 1'b1);
    run_burst(2, 5, 1'b1);
  endtask

  task automatic test_counter_loop();
    test_reset();
    use_ctr = 1'b1;
    run_burst(6, 300, 1'b0);
    checks++; if (pcnt_a !== 16'd300) begin errors++; $display("[TB] FAIL loop_pulse_cnt got %0d want 300", pcnt_a); end
    checks++; if (ccnt_a !== 16'd1) begin errors++; $display("[TB] FAIL loop_cout_cnt got %0d want 1", ccnt_a); end
    checks++; if (ctr_q !== 8'd44) begin errors++; $display("[TB] FAIL loop_counter_q got %0d want 44", ctr_q); end
    use_ctr = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    period = 16'd3;
    burst_len = 16'd5;
    start = 1'b1;
    cout_rand = 1'b0;
    cout_in2 = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (pcnt_a !== 16'd2 || pulse_a !== 1'b1) begin errors++; $display("[TB] FAIL mid_before_reset got cnt %0d pulse %b want cnt 2 pulse 1", pcnt_a, pulse_a); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if ({pulse_a, busy_a, done_a} !== 3'b000 || pcnt_a !== 16'd0) begin errors++; $display("[TB] FAIL mid_reset_a got %b cnt %0d want 000 cnt 0", {pulse_a, busy_a, done_a}, pcnt_a); end
    checks++; if ({pulse_b, busy_b, done_b} !== 3'b000 || pcnt_b !== 16'd0) begin errors++; $display("[TB] FAIL mid_reset_b got %b cnt %0d want 000 cnt 0", {pulse_b, busy_b, done_b}, pcnt_b); end
    for (int j = 0; j < 8; j++) begin
      @(posedge clk); #1;
      checks++; if ({pulse_a, busy_a, done_a} !== 3'b000) begin errors++; $display("[TB] FAIL mid_after_reset c%0d got %b want 000", j, {pulse_a, busy_a, done_a}); end
    end
    run_burst(3, 5, 1'b0);
  endtask

  task automatic test_saturation();
    int want;
    @(negedge clk);
    burst_len = 16'd0;
    start = 1'b1;
    cout_in2 = 1'b1;
    cout_rand = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (ccnt_b !== 2'd0) begin errors++; $display("[TB] FAIL sat_coincident got %0d want 0", ccnt_b); end
    for (int j = 1; j <= 4; j++) begin
      @(posedge clk); #1;
      want = (j > 3) ? 3 : j;
      checks++; if (ccnt_b !== 2'(want)) begin errors++; $display("[TB] FAIL sat_count c%0d got %0d want %0d", j, ccnt_b, want); end
    end
    cout_in2 = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++)
      run_burst(int'($urandom_range(0, 7)), int'($urandom_range(0, 6)), 1'($urandom % 2));
  endtask

  initial begin
    test_reset();
    test_basic();
    test_period_zero();
    test_zero_len();
    test_back_to_back();
    test_counter_loop();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired before test sequence completed");
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/pulse_burst_gen.md
Name: pulse_burst_gen

Overview:
- Stimulus-side partner of the cascadable counter: generates the single-cycle count-enable (cin) pulse train that a counter consumes, and counts the carry-out (cout) pulses it returns.
- Programmable pulse period and burst length, with a start/busy/done handshake.
- Sits beside counter_top-style blocks as an on-chip exerciser and rate source, so benches and self-test logic need no hand-written pulse loops.

Parameters:
- PER_W, 16, width of the period field (cycles between pulses).
- LEN_W, 16, width of the burst-length field and of pulse_cnt.
- CO_W, 16, width of the cout_cnt carry counter.

Ports:
- clk  in  1  system clock; every register updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  request a burst; sampled only in IDLE.
- period  in  PER_W  cycles from one pulse to the next; 0 is treated as 1.
- burst_len  in  LEN_W  number of pulses in the burst; 0 means no pulses.
- cout_in  in  1  carry-out returned by the driven counter.
- pulse_out  out  1  one-cycle count-enable pulse (drives the counter's cin).
- busy  out  1  high while a burst is in progress.
- done  out  1  one-cycle strobe when a burst completes.
- pulse_cnt  out  LEN_W  pulses issued in the current or last burst.
- cout_cnt  out  CO_W  cout_in pulses seen since the last accepted start; saturates at all-ones.

Behaviour:
- Reset: state IDLE, pulse_out=0, busy=0, done=0, pulse_cnt=0, cout_cnt=0. A reset mid-burst aborts at once; no done strobe is issued.
- States are IDLE, RUN and FIN.
- IDLE:
  - start=1 at edge k latches period (0 forced to 1) and burst_len, and clears pulse_cnt and cout_cnt.
  - If burst_len=0: go to FIN.
  - Otherwise: go to RUN, load the divider with period-1, and set busy=1 from cycle k+1.
- RUN:
  - Each cycle the divider decrements.
  - When it reaches 0: pulse_out=1 for exactly one cycle, pulse_cnt increments in the same cycle, and the divider reloads to period-1.
  - First pulse is high in cycle k+period; pulses are period cycles apart, so period=1 keeps pulse_out high continuously.
  - After the pulse that makes pulse_cnt equal burst_len, go to FIN.
- FIN: lasts one cycle.
  - done=1 and busy=0.
  - Next state is IDLE.
  - A new start is accepted in IDLE no earlier than the cycle after done.
- start while busy or in FIN is ignored; no queuing.
- period and burst_len are used only at acceptance; later changes do not affect the running burst.
- cout_in is counted every cycle outside reset, in any state; it is cleared only by reset or an accepted start.
  - If cout_in=1 in the same cycle a start is accepted, the clear wins and cout_cnt=0.
  - Saturation holds at 2^CO_W-1; no wrap.
- pulse_cnt holds its final value after done until the next accepted start.
- All outputs are registered; there is no combinational path from inputs to outputs.

Decomposition:
- Shared package pulse_gen_pkg holds:
  - state encoding constants ST_IDLE, ST_RUN, ST_FIN;
  - default widths PER_W_DEF, LEN_W_DEF, CO_W_DEF.
- One natural sub-module: pulse_divider (a loadable down-counter with a terminal-count strobe), also reusable as a generic prescaler.
- Handshake FSM and counters stay in the top.

Test Plan:
- Reset, then period=6, burst_len=3, one-cycle start at cycle 0 -> busy from cycle 1; pulses at cycles 6, 12, 18; done at cycle 19 with busy=0; pulse_cnt=3.
- period=6, burst_len=300, pulse_out wired to an 8-bit counter_top cin, cout wired back -> pulse_cnt=300, cout_cnt=1, counter q=44 after done.
- period=0, burst_len=4 -> pulse_out high for 4 consecutive cycles; done the cycle after the last pulse.
- burst_len=0 with start -> no pulse, busy stays 0, done one cycle after start; second start during a running burst -> ignored, pulse count unchanged.
- rst asserted mid-burst after 2 of 5 pulses -> all outputs 0 next cycle, no done; a fresh start then gives a full 5-pulse burst.
- CO_W=2 and 5 cout_in pulses, including one coincident with an accepted start -> coincident pulse dropped, count saturates at 3.
